// File: rtl/fios_pe_sequencer.sv
// fios_pe_sequencer: control sequencer for one FIOS Montgomery multiply
// on a 17-bit-word PE chain. Walks the outer loop over a-words (i) and
// the AB / MP inner loops over b/p-words (j), with an m-wait (w) between
// them. It drives the per-cycle PE control vector and the word addresses.
//
// Ports:
//   clock_i, reset_i      clock, synchronous active-high reset
//   start_i               one-cycle start request (ignored while busy)
//   busy_o, done_o        operation in flight / one-cycle completion pulse
//   a_reg_en_o            load a-word into PE
//   m_reg_en_o            capture m = RES[16:0]
//   mux_A/B/C_sel_o       PE operand mux selects
//   CREG_en_o             DSP C register enable
//   OPMODE_o              DSP OPMODE
//   RES_delay_en_o        feedback delay-line enable
//   a_idx_o, word_idx_o   outer (a-word) and inner (b/p-word) indices
module fios_pe_sequencer #(
    parameter int S     = 16,
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    localparam int L    = 1 + ABREG + MREG,
    localparam int IW   = $clog2(S)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          a_reg_en_o,
    output logic          m_reg_en_o,
    output logic [1:0]    mux_A_sel_o,
    output logic [1:0]    mux_B_sel_o,
    output logic [1:0]    mux_C_sel_o,
    output logic          CREG_en_o,
    output logic [8:0]    OPMODE_o,
    output logic          RES_delay_en_o,
    output logic [IW-1:0] a_idx_o,
    output logic [IW-1:0] word_idx_o
);

    localparam int WW = $clog2(L + 1);

    localparam logic [8:0] OPM_ZERO = 9'h000;
    localparam logic [8:0] OPM_MUL  = 9'h005;
    localparam logic [8:0] OPM_MAC  = 9'h035;

    localparam logic [1:0] A_AREG = 2'd0;
    localparam logic [1:0] A_RES  = 2'd1;
    localparam logic [1:0] A_MREG = 2'd2;
    localparam logic [1:0] A_ZERO = 2'd3;

    localparam logic [1:0] B_BW   = 2'd0;
    localparam logic [1:0] B_PP0  = 2'd1;
    localparam logic [1:0] B_PW   = 2'd2;
    localparam logic [1:0] B_ZERO = 2'd3;

    localparam logic [1:0] C_CIN  = 2'd0;
    localparam logic [1:0] C_RESD = 2'd1;

    localparam logic [IW-1:0] J_LAST = IW'(S - 1);
    localparam logic [WW-1:0] W_LAST = WW'(L - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_AB,
        ST_MCALC,
        ST_MWAIT,
        ST_MP,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [WW-1:0] w_q, w_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          a_reg_en_q, a_reg_en_d;
    logic          m_reg_en_q, m_reg_en_d;
    logic [1:0]    mux_a_sel_q, mux_a_sel_d;
    logic [1:0]    mux_b_sel_q, mux_b_sel_d;
    logic [1:0]    mux_c_sel_q, mux_c_sel_d;
    logic          creg_en_q, creg_en_d;
    logic [8:0]    opmode_q, opmode_d;
    logic          res_delay_en_q, res_delay_en_d;
    logic [IW-1:0] a_idx_q, a_idx_d;
    logic [IW-1:0] word_idx_q, word_idx_d;

    logic j_last, i_last, w_last;

    assign j_last = (j_q == J_LAST);
    assign i_last = (i_q == J_LAST);
    assign w_last = (w_q == W_LAST);

    // Sequencing: counters and next state.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        w_d     = w_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_LOAD_A;
                    i_d     = '0;
                end
            end
            ST_LOAD_A: begin
                state_d = ST_AB;
                j_d     = '0;
            end
            ST_AB: begin
                if (j_last) begin
                    state_d = ST_MCALC;
                    j_d     = '0;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_MCALC: begin
                state_d = ST_MWAIT;
                w_d     = '0;
            end
            ST_MWAIT: begin
                if (w_last) begin
                    state_d = ST_MP;
                    w_d     = '0;
                    j_d     = '0;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            ST_MP: begin
                if (j_last) begin
                    j_d = '0;
                    if (i_last) begin
                        state_d = ST_DRAIN;
                        w_d     = '0;
                    end else begin
                        state_d = ST_LOAD_A;
                        i_d     = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_last) begin
                    state_d = ST_DONE;
                    w_d     = '0;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                i_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control vector is decoded from the *next* state so that, once
    // registered, it lines up with the cycles spent in that state.
    always_comb begin
        busy_d         = 1'b1;
        done_d         = 1'b0;
        a_reg_en_d     = 1'b0;
        m_reg_en_d     = 1'b0;
        mux_a_sel_d    = A_ZERO;
        mux_b_sel_d    = B_ZERO;
        mux_c_sel_d    = C_CIN;
        creg_en_d      = 1'b0;
        opmode_d       = OPM_ZERO;
        res_delay_en_d = 1'b0;
        a_idx_d        = i_d;
        word_idx_d     = '0;
        unique case (state_d)
            ST_IDLE: begin
                busy_d  = 1'b0;
                a_idx_d = '0;
            end
            ST_LOAD_A: begin
                a_reg_en_d = 1'b1;
            end
            ST_AB: begin
                mux_a_sel_d    = A_AREG;
                mux_b_sel_d    = B_BW;
                // First a-word starts from the external C; later ones
                // accumulate onto the fed-back partial result.
                mux_c_sel_d    = (i_d == '0) ? C_CIN : C_RESD;
                opmode_d       = OPM_MAC;
                creg_en_d      = 1'b1;
                res_delay_en_d = 1'b1;
                word_idx_d     = j_d;
            end
            ST_MCALC: begin
                mux_a_sel_d = A_RES;
                mux_b_sel_d = B_PP0;
                opmode_d    = OPM_MUL;
            end
            ST_MWAIT: begin
                // m emerges from the DSP pipe on the last wait cycle.
                m_reg_en_d = (w_d == W_LAST);
            end
            ST_MP: begin
                mux_a_sel_d    = A_MREG;
                mux_b_sel_d    = B_PW;
                mux_c_sel_d    = C_RESD;
                opmode_d       = OPM_MAC;
                creg_en_d      = 1'b1;
                res_delay_en_d = 1'b1;
                word_idx_d     = j_d;
            end
            ST_DRAIN: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            i_q            <= '0;
            j_q            <= '0;
            w_q            <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            a_reg_en_q     <= 1'b0;
            m_reg_en_q     <= 1'b0;
            mux_a_sel_q    <= A_ZERO;
            mux_b_sel_q    <= B_ZERO;
            mux_c_sel_q    <= C_CIN;
            creg_en_q      <= 1'b0;
            opmode_q       <= OPM_ZERO;
            res_delay_en_q <= 1'b0;
            a_idx_q        <= '0;
            word_idx_q     <= '0;
        end else begin
            state_q        <= state_d;
            i_q            <= i_d;
            j_q            <= j_d;
            w_q            <= w_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            a_reg_en_q     <= a_reg_en_d;
            m_reg_en_q     <= m_reg_en_d;
            mux_a_sel_q    <= mux_a_sel_d;
            mux_b_sel_q    <= mux_b_sel_d;
            mux_c_sel_q    <= mux_c_sel_d;
            creg_en_q      <= creg_en_d;
            opmode_q       <= opmode_d;
            res_delay_en_q <= res_delay_en_d;
            a_idx_q        <= a_idx_d;
            word_idx_q     <= word_idx_d;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign a_reg_en_o     = a_reg_en_q;
    assign m_reg_en_o     = m_reg_en_q;
    assign mux_A_sel_o    = mux_a_sel_q;
    assign mux_B_sel_o    = mux_b_sel_q;
    assign mux_C_sel_o    = mux_c_sel_q;
    assign CREG_en_o      = creg_en_q;
    assign OPMODE_o       = opmode_q;
    assign RES_delay_en_o = res_delay_en_q;
    assign a_idx_o        = a_idx_q;
    assign word_idx_o     = word_idx_q;

endmodule

// File: tb/tb_fios_pe_sequencer.sv
// tb_fios_pe_sequencer: scoreboard bench for fios_pe_sequencer.
// S=4 DUT checked every cycle plus a latency sweep over other sizes.
module tb_fios_pe_sequencer;

    localparam int S     = 4;
    localparam int ABREG = 1;
    localparam int MREG  = 1;
    localparam int L     = 1 + ABREG + MREG;
    localparam int LAT   = S * (2 * S + L + 2) + L + 1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       a_en;
        logic       m_en;
        logic [1:0] ma;
        logic [1:0] mb;
        logic [1:0] mc;
        logic       creg;
        logic [8:0] op;
        logic       rd;
        logic [1:0] ai;
        logic [1:0] wi;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic       busy_o;
    logic       done_o;
    logic       a_reg_en_o;
    logic       m_reg_en_o;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic [1:0] mux_c;
    logic       creg_en;
    logic [8:0] opmode;
    logic       res_delay_en;
    logic [1:0] a_idx;
    logic [1:0] word_idx;

    int vectors     = 0;
    int miscompares = 0;
    int fail_prints = 0;

    always #5 clk = ~clk;

    fios_pe_sequencer #(.S(S), .ABREG(ABREG), .MREG(MREG)) dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .a_reg_en_o     (a_reg_en_o),
        .m_reg_en_o     (m_reg_en_o),
        .mux_A_sel_o    (mux_a),
        .mux_B_sel_o    (mux_b),
        .mux_C_sel_o    (mux_c),
        .CREG_en_o      (creg_en),
        .OPMODE_o       (opmode),
        .RES_delay_en_o (res_delay_en),
        .a_idx_o        (a_idx),
        .word_idx_o     (word_idx)
    );

    // Sweep instances: (S,L) = (2,1) (2,2) (2,3) (64,3).
    logic       sw_start;
    logic       sw_busy[4];
    logic       sw_done[4];
    logic       sw_aen[4];
    logic       sw_men[4];
    logic [1:0] sw_ma[4];
    logic [1:0] sw_mb[4];
    logic [1:0] sw_mc[4];
    logic       sw_creg[4];
    logic [8:0] sw_op[4];
    logic       sw_rd[4];
    logic       sw_ai0, sw_wi0, sw_ai1, sw_wi1, sw_ai2, sw_wi2;
    logic [5:0] sw_ai3, sw_wi3;

    fios_pe_sequencer #(.S(2), .ABREG(0), .MREG(0)) sw0 (
        .clock_i(clk), .reset_i(reset_i), .start_i(sw_start),
        .busy_o(sw_busy[0]), .done_o(sw_done[0]),
        .a_reg_en_o(sw_aen[0]), .m_reg_en_o(sw_men[0]),
        .mux_A_sel_o(sw_ma[0]), .mux_B_sel_o(sw_mb[0]),
        .mux_C_sel_o(sw_mc[0]), .CREG_en_o(sw_creg[0]),
        .OPMODE_o(sw_op[0]), .RES_delay_en_o(sw_rd[0]),
        .a_idx_o(sw_ai0), .word_idx_o(sw_wi0)
    );

    fios_pe_sequencer #(.S(2), .ABREG(1), .MREG(0)) sw1 (
        .clock_i(clk), .reset_i(reset_i), .start_i(sw_start),
        .busy_o(sw_busy[1]), .done_o(sw_done[1]),
        .a_reg_en_o(sw_aen[1]), .m_reg_en_o(sw_men[1]),
        .mux_A_sel_o(sw_ma[1]), .mux_B_sel_o(sw_mb[1]),
        .mux_C_sel_o(sw_mc[1]), .CREG_en_o(sw_creg[1]),
        .OPMODE_o(sw_op[1]), .RES_delay_en_o(sw_rd[1]),
        .a_idx_o(sw_ai1), .word_idx_o(sw_wi1)
    );

    fios_pe_sequencer #(.S(2), .ABREG(1), .MREG(1)) sw2 (
        .clock_i(clk), .reset_i(reset_i), .start_i(sw_start),
        .busy_o(sw_busy[2]), .done_o(sw_done[2]),
        .a_reg_en_o(sw_aen[2]), .m_reg_en_o(sw_men[2]),
        .mux_A_sel_o(sw_ma[2]), .mux_B_sel_o(sw_mb[2]),
        .mux_C_sel_o(sw_mc[2]), .CREG_en_o(sw_creg[2]),
        .OPMODE_o(sw_op[2]), .RES_delay_en_o(sw_rd[2]),
        .a_idx_o(sw_ai2), .word_idx_o(sw_wi2)
    );

    fios_pe_sequencer #(.S(64), .ABREG(1), .MREG(1)) sw3 (
        .clock_i(clk), .reset_i(reset_i), .start_i(sw_start),
        .busy_o(sw_busy[3]), .done_o(sw_done[3]),
        .a_reg_en_o(sw_aen[3]), .m_reg_en_o(sw_men[3]),
        .mux_A_sel_o(sw_ma[3]), .mux_B_sel_o(sw_mb[3]),
        .mux_C_sel_o(sw_mc[3]), .CREG_en_o(sw_creg[3]),
        .OPMODE_o(sw_op[3]), .RES_delay_en_o(sw_rd[3]),
        .a_idx_o(sw_ai3), .word_idx_o(sw_wi3)
    );

    // Reference model: an accepted start expands into the full list of
    // per-cycle control vectors for the operation.
    vec_t exp_q[$];
    bit   cur_idle = 1'b0;

    function automatic vec_t idle_v();
        vec_t v;
        v    = '0;
        v.ma = 2'd3;
        v.mb = 2'd3;
        return v;
    endfunction

    function automatic vec_t busy_v(input int i);
        vec_t v;
        v      = idle_v();
        v.busy = 1'b1;
        v.ai   = 2'(i);
        return v;
    endfunction

    task automatic push_op();
        vec_t v;
        for (int i = 0; i < S; i++) begin
            v      = busy_v(i);
            v.a_en = 1'b1;
            exp_q.push_back(v);
            for (int j = 0; j < S; j++) begin
                v      = busy_v(i);
                v.ma   = 2'd0;
                v.mb   = 2'd0;
                v.mc   = (i == 0) ? 2'd0 : 2'd1;
                v.op   = 9'h035;
                v.creg = 1'b1;
                v.rd   = 1'b1;
                v.wi   = 2'(j);
                exp_q.push_back(v);
            end
            v    = busy_v(i);
            v.ma = 2'd1;
            v.mb = 2'd1;
            v.op = 9'h005;
            exp_q.push_back(v);
            for (int w = 0; w < L; w++) begin
                v      = busy_v(i);
                v.m_en = (w == L - 1);
                exp_q.push_back(v);
            end
            for (int j = 0; j < S; j++) begin
                v      = busy_v(i);
                v.ma   = 2'd2;
                v.mb   = 2'd2;
                v.mc   = 2'd1;
                v.op   = 9'h035;
                v.creg = 1'b1;
                v.rd   = 1'b1;
                v.wi   = 2'(j);
                exp_q.push_back(v);
            end
        end
        for (int d = 0; d < L; d++) exp_q.push_back(busy_v(S - 1));
        v      = busy_v(S - 1);
        v.done = 1'b1;
        exp_q.push_back(v);
    endtask

    // Issue side: decide at each edge what the next cycles must show.
    always @(posedge clk) begin
        if (reset_i) exp_q.delete();
        else if (start_i && cur_idle && exp_q.size() == 0) push_op();
    end

    // Monitor: pops one expected vector per cycle, IDLE when none queued.
    always @(negedge clk) begin
        vec_t e;
        vec_t a;
        if (exp_q.size() > 0) begin
            e        = exp_q.pop_front();
            cur_idle = 1'b0;
        end else begin
            e        = idle_v();
            cur_idle = 1'b1;
        end
        a.busy = busy_o;
        a.done = done_o;
        a.a_en = a_reg_en_o;
        a.m_en = m_reg_en_o;
        a.ma   = mux_a;
        a.mb   = mux_b;
        a.mc   = mux_c;
        a.creg = creg_en;
        a.op   = opmode;
        a.rd   = res_delay_en;
        a.ai   = a_idx;
        a.wi   = word_idx;
        vectors++;
        if (a !== e) begin
            miscompares++;
            if (fail_prints < 30) begin
                fail_prints++;
                $display("FAIL vec t=%0t got=%h want=%h", $time, a, e);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic step(input logic s, input logic r);
        start_i = s;
        reset_i = r;
        @(negedge clk);
    endtask

    // Start, then run until done_o; optional extra start pulse while busy
    // and optional reset. Start is also pulsed in the done_o cycle.
    task automatic run_to_done(input int pulse_at, input int rst_at,
                               output int done_at);
        int c;
        done_at = 0;
        step(1'b1, 1'b0);
        c = 1;
        while (c <= LAT + 40 && done_at == 0) begin
            if (done_o) done_at = c;
            if (rst_at > 0 && c == rst_at + 1)
                chk("busy_after_rst", int'(busy_o), 0);
            step((c == pulse_at || done_at != 0), (c == rst_at));
            c++;
        end
    endtask

    initial begin
        int d;
        int cnt[4];
        int lat[4];
        int aen[4];
        int maxai[4];
        int ai_now[4];
        int ss[4];
        int ll[4];

        ss = '{2, 2, 2, 64};
        ll = '{1, 2, 3, 3};
        reset_i  = 1'b1;
        start_i  = 1'b0;
        sw_start = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_muxA", int'(mux_a), 3);
        chk("rst_muxB", int'(mux_b), 3);
        chk("rst_opmode", int'(opmode), 0);

        run_to_done(5, 0, d);
        chk("lat_first", d, LAT);
        chk("gap_busy", int'(busy_o), 0);

        run_to_done(0, 0, d);
        chk("lat_back2back", d, LAT);

        run_to_done(0, 20, d);
        chk("done_after_rst", d, 0);

        run_to_done(0, 0, d);
        chk("lat_after_rst", d, LAT);

        for (int n = 0; n < 3000; n++)
            step($urandom_range(7) == 0, $urandom_range(399) == 0);

        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            cnt[n]   = 0;
            lat[n]   = 0;
            aen[n]   = 0;
            maxai[n] = 0;
        end
        sw_start = 1'b1;
        @(negedge clk);
        sw_start = 1'b0;
        for (int c = 0; c < 9000; c++) begin
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0)
                break;
            ai_now[0] = int'(sw_ai0);
            ai_now[1] = int'(sw_ai1);
            ai_now[2] = int'(sw_ai2);
            ai_now[3] = int'(sw_ai3);
            for (int n = 0; n < 4; n++) begin
                if (lat[n] == 0) begin
                    if (sw_busy[n]) cnt[n]++;
                    if (sw_aen[n]) aen[n]++;
                    if (sw_busy[n] && ai_now[n] > maxai[n])
                        maxai[n] = ai_now[n];
                    if (sw_done[n]) lat[n] = cnt[n];
                end
            end
            @(negedge clk);
        end
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("sweep_lat[%0d]", n), lat[n],
                ss[n] * (2 * ss[n] + ll[n] + 2) + ll[n] + 1);
            chk($sformatf("sweep_maxai[%0d]", n), maxai[n], ss[n] - 1);
            chk($sformatf("sweep_aen[%0d]", n), aen[n], ss[n]);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
